bus_ram_responder: RTL and testbench
====================================

// Module: bus_ram_responder
// PURPOSE
//  Target side of the core's active-low address-strobe bus (AS_L/WE_L/RAM_Select/address/data_out).
//  Decodes a selected cycle, inserts programmable wait states, then reads or writes a word RAM
//  with byte enables and returns DTACK_L. Also has a backdoor load port for the bench/boot loader.
//  Sits between risc_v_core's bus master and on-chip data RAM.
// PARAMETERS
//  ADDR_W       10   byte-address width; word index = address[ADDR_W-1:2]
//  DEPTH        256  words of storage; must equal 2**(ADDR_W-2)
//  WAIT_STATES  1    extra cycles between request capture and acknowledge (0..15)
// PORTS
//  CLOCK_50    in   1       sole clock, rising edge
//  RESET_L     in   1       asynchronous, active-low reset (driven from KEY[0])
//  AS_L        in   1       address strobe, active-low; held low for whole cycle by master
//  WE_L        in   1       0 = write, 1 = read; sampled with AS_L
//  RAM_Select  in   1       chip select, active-high
//  address     in   ADDR_W  byte address; bits [1:0] ignored
//  byte_en     in   4       active-high byte lanes for writes; ignored on reads
//  data_in     in   32      write data from master
//  data_out    out  32      read data; valid while DTACK_L = 0 on a read
//  DTACK_L     out  1       data acknowledge, active-low
//  load_we     in   1       backdoor word write strobe
//  load_addr   in   ADDR_W  backdoor byte address (bits [1:0] ignored)
//  load_data   in   32      backdoor write data (all four lanes written)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, DTACK_L=1, data_out=0, wait counter=0. RAM not cleared.
//  States: IDLE -> WAIT -> ACK -> IDLE.
//   IDLE: on edge with AS_L=0 & RAM_Select=1: latch addr index, WE_L, byte_en, data_in;
//         cnt<=WAIT_STATES; go WAIT. Otherwise stay.
//   WAIT: if AS_L=1 (master abort): no RAM access, go IDLE. Else if cnt!=0: cnt--.
//         Else if load_we=1: hold (bus commit stalls one cycle per load cycle).
//         Else commit: write -> RAM[idx] updated on lanes with byte_en=1; read -> data_out<=RAM[idx];
//         DTACK_L<=0; go ACK.
//   ACK: DTACK_L held 0, data_out held, while AS_L=0. When AS_L sampled 1: DTACK_L<=1, go IDLE.
//         New request needs AS_L high for >=1 edge; back-to-back without strobe release is not a new cycle.
//  Latency: request sampled at edge 0 -> DTACK_L low after edge WAIT_STATES+1 (no load collision).
//  data_out changes only on read commits and reset; writes leave it unchanged.
//  Address wrap: index = address[ADDR_W-1:2]; bits above are absent, so no out-of-range case.
//  Backdoor: load_we writes RAM[load_addr[ADDR_W-1:2]]=load_data on that edge in any state;
//   always wins over a same-edge bus commit (commit deferred, sees loaded value).
//  RAM_Select=0 with AS_L=0: ignored, DTACK_L stays 1 (another target responds).
//  Reset mid-WAIT: no write performed; mid-ACK: DTACK_L released immediately.
// STRUCTURE
//  bus_pkg: typedef enum logic [1:0] {S_IDLE,S_WAIT,S_ACK} bus_state_t; localparam BUS_DATA_W=32.
//  Sub-module ram_be_32 (DEPTH x 32, one write port with 4 byte enables, registered read,
//   arbitration mux for backdoor vs bus port lives in bus_ram_responder).
//  Elaboration check: DEPTH == 2**(ADDR_W-2), WAIT_STATES <= 15.
// TESTING
//  1 Reset: assert RESET_L=0 mid-clock -> DTACK_L=1, data_out=0 immediately, before next edge.
//  2 Write 0xAABBCCDD @0x010 be=4'hF, read @0x010 -> data_out=0xAABBCCDD, DTACK_L low exactly
//    2 edges after request (WAIT_STATES=1); DTACK_L high one edge after AS_L rises.
//  3 Byte lanes: write 0x11223344 be=4'b0010 @0x010, read -> 0xAABB33DD.
//  4 Abort: start write 0xDEADBEEF @0x020 (preloaded 0), raise AS_L during WAIT -> DTACK_L never low,
//    read @0x020 -> 0x00000000.
//  5 Backdoor collision: load_we @0x030=0x12345678 on bus commit edge of read @0x030 -> DTACK
//    delayed 1 cycle, data_out=0x12345678; wrap: read @0x430 (ADDR_W=10 drops bit 10) -> same word.
//  6 Reset mid-WAIT of write 0xCAFEF00D @0x040 -> word unchanged, FSM IDLE, next read acks normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the address-strobe bus RAM target.
package bus_pkg;

  localparam int BUS_DATA_W = 32;
  localparam int BUS_BE_W   = BUS_DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACK
  } bus_state_t;

endpackage

// File: rtl/ram_be_32.sv
// Word RAM with a single byte-lane write port and a registered read port.
// Contents are not reset; only the read register is.
module ram_be_32
  import bus_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [BUS_BE_W-1:0]   be,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [BUS_DATA_W-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [BUS_DATA_W-1:0] rdata
);

  logic [BUS_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < BUS_BE_W; b++) begin
      if (we && be[b]) begin
        mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/bus_ram_responder.sv
// Bus target: captures a strobed request, waits WAIT_STATES cycles, commits to RAM,
// then holds DTACK_L low until the master releases AS_L.
//
//  state  | meaning
//  S_IDLE | no cycle in progress, watching for AS_L low with RAM_Select
//  S_WAIT | request latched, counting wait states / stalled by backdoor load
//  S_ACK  | RAM access done, DTACK_L low until AS_L is released
module bus_ram_responder
  import bus_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_L,
  input  logic                  AS_L,
  input  logic                  WE_L,
  input  logic                  RAM_Select,
  input  logic [ADDR_W-1:0]     address,
  input  logic [BUS_BE_W-1:0]   byte_en,
  input  logic [BUS_DATA_W-1:0] data_in,
  output logic [BUS_DATA_W-1:0] data_out,
  output logic                  DTACK_L,
  input  logic                  load_we,
  input  logic [ADDR_W-1:0]     load_addr,
  input  logic [BUS_DATA_W-1:0] load_data
);

  localparam int         IDX_W     = ADDR_W - 2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  if (DEPTH != (1 << IDX_W)) begin : g_depth_check
    $error("bus_ram_responder: DEPTH must equal 2**(ADDR_W-2)");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_wait_check
    $error("bus_ram_responder: WAIT_STATES must be in 0..15");
  end

  bus_state_t            state;
  logic [3:0]            cnt;
  logic [IDX_W-1:0]      idx_q;
  logic                  write_q;
  logic [BUS_BE_W-1:0]   be_q;
  logic [BUS_DATA_W-1:0] wdata_q;
  logic                  commit;

  logic                  ram_we;
  logic                  ram_re;
  logic [BUS_BE_W-1:0]   ram_be;
  logic [IDX_W-1:0]      ram_waddr;
  logic [BUS_DATA_W-1:0] ram_wdata;

  // Byte-offset bits carry no meaning for a word RAM.
  logic unused_lsb;
  assign unused_lsb = ^{address[1:0], load_addr[1:0]};

  // A backdoor load on the commit edge pushes the commit out by a cycle,
  // so the single write port never sees two writers at once.
  assign commit = (state == S_WAIT) && !AS_L && (cnt == 4'd0) && !load_we;

  always_ff @(posedge CLOCK_50 or negedge RESET_L) begin
    if (!RESET_L) begin
      state   <= S_IDLE;
      cnt     <= '0;
      DTACK_L <= 1'b1;
      idx_q   <= '0;
      write_q <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!AS_L && RAM_Select) begin
            idx_q   <= address[ADDR_W-1:2];
            write_q <= !WE_L;
            be_q    <= byte_en;
            wdata_q <= data_in;
            cnt     <= WAIT_INIT;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (AS_L) begin
            state <= S_IDLE;
          end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else if (!load_we) begin
            DTACK_L <= 1'b0;
            state   <= S_ACK;
          end
        end
        S_ACK: begin
          if (AS_L) begin
            DTACK_L <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: begin
          DTACK_L <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_be    = be_q;
    ram_waddr = idx_q;
    ram_wdata = wdata_q;
    if (load_we) begin
      ram_we    = 1'b1;
      ram_be    = '1;
      ram_waddr = load_addr[ADDR_W-1:2];
      ram_wdata = load_data;
    end else if (commit) begin
      ram_we = write_q;
      ram_re = !write_q;
    end
  end

  ram_be_32 #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_ram (
    .clk   (CLOCK_50),
    .rst_n (RESET_L),
    .we    (ram_we),
    .be    (ram_be),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (idx_q),
    .rdata (data_out)
  );

endmodule

// File: tb/tb_bus_ram_responder.sv
// Self-checking bench for bus_ram_responder: directed table, corner sequences, random traffic.
module tb_bus_ram_responder;

  localparam int WS = 1;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_L = 1'b0;
  logic        AS_L = 1'b1;
  logic        WE_L = 1'b1;
  logic        RAM_Select = 1'b0;
  logic [9:0]  address = '0;
  logic [3:0]  byte_en = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        DTACK_L;
  logic        load_we = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [31:0] load_data = '0;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] model_mem [256];
  logic [31:0] last_read = '0;

  bus_ram_responder #(.ADDR_W(10), .DEPTH(256), .WAIT_STATES(WS)) dut (
    .CLOCK_50(CLOCK_50), .RESET_L(RESET_L), .AS_L(AS_L), .WE_L(WE_L),
    .RAM_Select(RAM_Select), .address(address), .byte_en(byte_en),
    .data_in(data_in), .data_out(data_out), .DTACK_L(DTACK_L),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bd_load(input logic [15:0] addr, input logic [31:0] d);
    @(negedge CLOCK_50);
    load_we = 1'b1; load_addr = addr[9:0]; load_data = d;
    @(posedge CLOCK_50); #1;
    load_we = 1'b0;
    model_mem[addr[9:2]] = d;
  endtask

  // Runs one strobed cycle; lat = edges after the sampling edge until DTACK_L low, -1 if never.
  task automatic bus_xfer(input logic wr, input logic [15:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input int load_at, input logic [15:0] laddr,
                          input logic [31:0] ldata, input int abort_at,
                          output int lat, output logic [31:0] rd);
    lat = -1; rd = '0;
    @(negedge CLOCK_50);
    AS_L = 1'b0; WE_L = !wr; RAM_Select = 1'b1;
    address = addr[9:0]; byte_en = be; data_in = wd;
    for (int k = 0; k < 20; k++) begin
      load_we = (k == load_at); load_addr = laddr[9:0]; load_data = ldata;
      if (k == abort_at) AS_L = 1'b1;
      @(posedge CLOCK_50); #1;
      if (DTACK_L == 1'b0) begin
        lat = k; rd = data_out;
        break;
      end
      @(negedge CLOCK_50);
    end
    @(negedge CLOCK_50);
    load_we = 1'b0; AS_L = 1'b1; RAM_Select = 1'b0;
    @(posedge CLOCK_50); #1;
    check("dtack_release", {31'b0, DTACK_L}, 32'd1);
  endtask

  // Applies one cycle to the reference model and checks the DUT against it.
  task automatic xfer_and_check(input string name, input logic wr, input logic [15:0] addr,
                                input logic [3:0] be, input logic [31:0] wd, input int load_at,
                                input logic [15:0] laddr, input logic [31:0] ldata,
                                input int abort_at, output int lat, output logic [31:0] rd);
    int commit_edge;
    bit aborted;
    int exp_lat;
    logic [31:0] exp_rd;
    logic [7:0] idx;
    commit_edge = WS + 1 + ((load_at == WS + 1) ? 1 : 0);
    aborted = (abort_at >= 1) && (abort_at <= commit_edge);
    if (load_at >= 0) model_mem[laddr[9:2]] = ldata;
    idx = addr[9:2];
    exp_rd = last_read;
    if (!aborted) begin
      if (wr) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
      end else begin
        exp_rd = model_mem[idx];
      end
      last_read = exp_rd;
    end
    exp_lat = aborted ? -1 : commit_edge;
    bus_xfer(wr, addr, be, wd, load_at, laddr, ldata, abort_at, lat, rd);
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    if (!aborted) check({name, "_data"}, rd, exp_rd);
  endtask

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[6];

  initial begin
    int lat;
    logic [31:0] rd;
    bit seen_low;

    vt[0] = '{1'b1, 16'h010, 4'hF, 32'hAABBCCDD, 32'h00000000};
    vt[1] = '{1'b0, 16'h010, 4'h0, 32'h0,        32'hAABBCCDD};
    vt[2] = '{1'b1, 16'h010, 4'h2, 32'h11223344, 32'hAABBCCDD};
    vt[3] = '{1'b0, 16'h010, 4'h0, 32'h0,        32'hAABB33DD};
    vt[4] = '{1'b1, 16'h410, 4'h9, 32'h55667788, 32'hAABB33DD};
    vt[5] = '{1'b0, 16'h010, 4'h0, 32'h0,        32'h55BB3388};

    #25;
    check("reset_dtack", {31'b0, DTACK_L}, 32'd1);
    check("reset_data_out", data_out, 32'h0);
    @(negedge CLOCK_50);
    RESET_L = 1'b1;

    for (int i = 0; i < 256; i++) bd_load(16'(i * 4), $urandom);

    for (int i = 0; i < 6; i++) begin
      xfer_and_check($sformatf("vec%0d", i), vt[i].wr, vt[i].addr, vt[i].be, vt[i].wd,
                     -1, 16'h0, 32'h0, -1, lat, rd);
      check($sformatf("vec%0d_table", i), rd, vt[i].exp);
    end

    // Master abort during WAIT leaves the word untouched.
    bd_load(16'h020, 32'h0);
    xfer_and_check("abort", 1'b1, 16'h020, 4'hF, 32'hDEADBEEF, -1, 16'h0, 32'h0, 1, lat, rd);
    xfer_and_check("abort_read", 1'b0, 16'h020, 4'h0, 32'h0, -1, 16'h0, 32'h0, -1, lat, rd);
    check("abort_read_const", rd, 32'h0);

    // Backdoor load on the commit edge stalls the commit and is visible to it.
    xfer_and_check("collide", 1'b0, 16'h030, 4'h0, 32'h0, WS + 1, 16'h030, 32'h12345678, -1, lat, rd);
    check("collide_lat_const", 32'(lat), 32'd3);
    check("collide_data_const", rd, 32'h12345678);
    xfer_and_check("wrap", 1'b0, 16'h430, 4'h0, 32'h0, -1, 16'h0, 32'h0, -1, lat, rd);
    check("wrap_const", rd, 32'h12345678);

    // Strobe without chip select is ignored.
    @(negedge CLOCK_50);
    AS_L = 1'b0; WE_L = 1'b0; RAM_Select = 1'b0; address = 10'h050;
    byte_en = 4'hF; data_in = 32'hFFFFFFFF;
    seen_low = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLOCK_50); #1;
      if (DTACK_L == 1'b0) seen_low = 1'b1;
    end
    check("unselected_no_ack", {31'b0, seen_low}, 32'd0);
    @(negedge CLOCK_50);
    AS_L = 1'b1;
    xfer_and_check("unselected_read", 1'b0, 16'h050, 4'h0, 32'h0, -1, 16'h0, 32'h0, -1, lat, rd);

    // Reset while in ACK releases DTACK_L and clears data_out without a clock edge.
    @(negedge CLOCK_50);
    AS_L = 1'b0; WE_L = 1'b1; RAM_Select = 1'b1; address = 10'h010;
    seen_low = 1'b0;
    for (int k = 0; k < 20 && !seen_low; k++) begin
      @(posedge CLOCK_50); #1;
      if (DTACK_L == 1'b0) seen_low = 1'b1;
    end
    check("mid_ack_reached", {31'b0, seen_low}, 32'd1);
    #4;
    RESET_L = 1'b0;
    #1;
    check("mid_ack_reset_dtack", {31'b0, DTACK_L}, 32'd1);
    check("mid_ack_reset_data", data_out, 32'h0);
    last_read = '0;
    @(negedge CLOCK_50);
    AS_L = 1'b1; RAM_Select = 1'b0;
    @(negedge CLOCK_50);
    RESET_L = 1'b1;

    // Make data_out non-zero, then reset in the middle of a write's WAIT.
    xfer_and_check("pre_wait_rd", 1'b0, 16'h010, 4'h0, 32'h0, -1, 16'h0, 32'h0, -1, lat, rd);
    @(negedge CLOCK_50);
    AS_L = 1'b0; WE_L = 1'b0; RAM_Select = 1'b1; address = 10'h040;
    byte_en = 4'hF; data_in = 32'hCAFEF00D;
    @(posedge CLOCK_50); #4;
    RESET_L = 1'b0;
    #1;
    check("mid_wait_reset_dtack", {31'b0, DTACK_L}, 32'd1);
    check("mid_wait_reset_data", data_out, 32'h0);
    last_read = '0;
    @(negedge CLOCK_50);
    AS_L = 1'b1; RAM_Select = 1'b0;
    @(negedge CLOCK_50);
    RESET_L = 1'b1;
    xfer_and_check("post_reset_rd", 1'b0, 16'h040, 4'h0, 32'h0, -1, 16'h0, 32'h0, -1, lat, rd);

    // Random traffic with occasional aborts and backdoor loads.
    for (int t = 0; t < 80; t++) begin
      logic        wr;
      logic [15:0] a;
      logic [15:0] la;
      int          mode;
      int          load_at;
      int          abort_at;
      wr = 1'($urandom_range(0, 1));
      a = 16'($urandom_range(0, 2047));
      la = ($urandom_range(0, 1) == 1) ? a : 16'($urandom_range(0, 1023));
      mode = $urandom_range(0, 5);
      load_at = -1; abort_at = -1;
      if (mode == 3) load_at = WS + 1;
      if (mode == 4) load_at = $urandom_range(0, WS);
      if (mode == 5) abort_at = $urandom_range(1, WS + 1);
      xfer_and_check($sformatf("rand%0d", t), wr, a, 4'($urandom_range(0, 15)), $urandom,
                     load_at, la, $urandom, abort_at, lat, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
